// File: rtl/apu_initiator.sv
`default_nettype none
// ============================================================================
// Module      : apu_initiator
// Description : Single-outstanding APU request initiator with response
//               buffering, request timeout and spurious-result detection.
// Revision    : 1.0 - initial release
// ============================================================================
module apu_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_op,
    input  logic [31:0] cmd_operands [2:0],
    input  logic [14:0] cmd_flags,
    output logic        apu_req,
    output logic [5:0]  apu_op,
    output logic [31:0] apu_operands [2:0],
    output logic [14:0] apu_flags_o,
    input  logic        apu_gnt,
    input  logic        apu_rvalid,
    input  logic [31:0] apu_result,
    input  logic [4:0]  apu_flags_i,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        err_spurious
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    // A zero timeout still needs a one-bit counter so the declarations stay legal.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [5:0]         r_op;
    logic [31:0]        r_operands [2:0];
    logic [14:0]        r_flags;
    logic [31:0]        r_result;
    logic [4:0]         r_rflags;
    logic               r_timeout;
    logic               r_err_spurious;
    logic               w_expire;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int c_LAST = TIMEOUT_CYCLES - 1;
            assign w_expire = (r_cnt == c_LAST[c_CNT_W-1:0]);
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state        <= c_IDLE;
            r_cnt          <= '0;
            r_op           <= '0;
            r_operands     <= '{default: '0};
            r_flags        <= '0;
            r_result       <= '0;
            r_rflags       <= '0;
            r_timeout      <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            // A result with nothing outstanding is flagged but never captured.
            if (apu_rvalid && (r_state == c_IDLE || r_state == c_RESP)) begin
                r_err_spurious <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op;
                        r_operands <= cmd_operands;
                        r_flags    <= cmd_flags;
                        r_cnt      <= '0;
                        r_state    <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (apu_gnt && apu_rvalid) begin
                        r_result  <= apu_result;
                        r_rflags  <= apu_flags_i;
                        r_timeout <= 1'b0;
                        r_state   <= c_RESP;
                    end else if (w_expire) begin
                        r_result  <= '0;
                        r_rflags  <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (apu_gnt) begin
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (apu_rvalid) begin
                        r_result  <= apu_result;
                        r_rflags  <= apu_flags_i;
                        r_timeout <= 1'b0;
                        r_state   <= c_RESP;
                    end else if (w_expire) begin
                        r_result  <= '0;
                        r_rflags  <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign cmd_ready    = (r_state == c_IDLE);
    assign apu_req      = (r_state == c_REQ);
    assign rsp_valid    = (r_state == c_RESP);
    assign busy         = (r_state != c_IDLE);
    assign apu_op       = r_op;
    assign apu_operands = r_operands;
    assign apu_flags_o  = r_flags;
    assign rsp_result   = r_result;
    assign rsp_flags    = r_rflags;
    assign rsp_timeout  = r_timeout;
    assign err_spurious = r_err_spurious;

endmodule
`default_nettype wire

// File: tb/tb_apu_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_apu_initiator
// Description : Directed self-checking bench for apu_initiator (timeout = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apu_initiator;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_op;
    logic [31:0] cmd_operands [2:0];
    logic [14:0] cmd_flags;
    logic        apu_req;
    logic [5:0]  apu_op;
    logic [31:0] apu_operands [2:0];
    logic [14:0] apu_flags_o;
    logic        apu_gnt;
    logic        apu_rvalid;
    logic [31:0] apu_result;
    logic [4:0]  apu_flags_i;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic        rsp_timeout;
    logic        busy;
    logic        err_spurious;

    int errors = 0;
    int checks = 0;

    apu_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .n_reset(n_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_operands(cmd_operands), .cmd_flags(cmd_flags),
        .apu_req(apu_req), .apu_op(apu_op), .apu_operands(apu_operands),
        .apu_flags_o(apu_flags_o), .apu_gnt(apu_gnt), .apu_rvalid(apu_rvalid),
        .apu_result(apu_result), .apu_flags_i(apu_flags_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .busy(busy),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] o2, input logic [31:0] o1,
                         input logic [31:0] o0, input logic [14:0] fl);
        cmd_valid       = 1'b1;
        cmd_op          = op;
        cmd_operands[2] = o2;
        cmd_operands[1] = o1;
        cmd_operands[0] = o0;
        cmd_flags       = fl;
        tick();
        cmd_valid       = 1'b0;
        cmd_op          = 6'h3f;
        cmd_operands    = '{default: 32'hffff_ffff};
        cmd_flags       = 15'h7fff;
    endtask

    task automatic test_reset();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if ({apu_req, rsp_valid, rsp_timeout, busy, err_spurious} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {apu_req, rsp_valid, rsp_timeout, busy, err_spurious}); end
        checks++; if ({apu_op, apu_flags_o, apu_operands[0], apu_operands[1], apu_operands[2]} !== '0) begin errors++; $display("FAIL reset_latched: got op=%h fl=%h expected 0", apu_op, apu_flags_o); end
        checks++; if ({rsp_result, rsp_flags} !== '0) begin errors++; $display("FAIL reset_rsp: got %h/%h expected 0/0", rsp_result, rsp_flags); end
    endtask

    task automatic test_single_cycle();
        issue(6'h01, 32'd0, 32'd0, 32'd5, 15'h0123);
        checks++; if ({apu_req, cmd_ready, busy} !== 3'b101) begin errors++; $display("FAIL single_req: got req/rdy/busy=%b expected 101", {apu_req, cmd_ready, busy}); end
        checks++; if (apu_op !== 6'h01 || apu_operands[0] !== 32'd5 || apu_operands[2] !== 32'd0 || apu_flags_o !== 15'h0123) begin errors++; $display("FAIL single_latch: got op=%h o0=%h fl=%h expected 01/5/0123", apu_op, apu_operands[0], apu_flags_o); end
        apu_gnt = 1'b1; apu_rvalid = 1'b1; apu_result = 32'h5; apu_flags_i = 5'h03;
        tick();
        apu_gnt = 1'b0; apu_rvalid = 1'b0; apu_result = 32'h0; apu_flags_i = 5'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h5 || rsp_flags !== 5'h03 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL single_rsp: got v=%b r=%h f=%h t=%b expected 1/5/03/0", rsp_valid, rsp_result, rsp_flags, rsp_timeout); end
        checks++; if (cmd_ready !== 1'b0 || apu_req !== 1'b0) begin errors++; $display("FAIL single_resp_state: got rdy=%b req=%b expected 0/0", cmd_ready, apu_req); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_return: got rdy=%b v=%b busy=%b expected 1/0/0", cmd_ready, rsp_valid, busy); end
    endtask

    task automatic test_stalled_grant();
        int req_cycles = 0;
        issue(6'h12, 32'hA2, 32'hA1, 32'hA0, 15'h0042);
        for (int i = 0; i < 4; i++) begin
            if (apu_req === 1'b1) req_cycles++;
            checks++; if (apu_operands[0] !== 32'hA0 || apu_operands[1] !== 32'hA1 || apu_operands[2] !== 32'hA2 || apu_op !== 6'h12) begin errors++; $display("FAIL stall_operands%0d: got %h %h %h expected a0 a1 a2", i, apu_operands[0], apu_operands[1], apu_operands[2]); end
            apu_gnt = (i == 3);
            tick();
        end
        apu_gnt = 1'b0;
        if (apu_req === 1'b1) req_cycles++;
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_wait: got busy=%b v=%b expected 1/0", busy, rsp_valid); end
        tick();
        if (apu_req === 1'b1) req_cycles++;
        apu_rvalid = 1'b1; apu_result = 32'hDEAD_BEEF; apu_flags_i = 5'h1A;
        tick();
        apu_rvalid = 1'b0; apu_result = 32'h0; apu_flags_i = 5'h0;
        checks++; if (req_cycles !== 4) begin errors++; $display("FAIL stall_req_cycles: got %0d expected 4", req_cycles); end
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hDEAD_BEEF || rsp_flags !== 5'h1A || rsp_timeout !== 1'b0) begin errors++; $display("FAIL stall_rsp: got v=%b r=%h f=%h t=%b expected 1/deadbeef/1a/0", rsp_valid, rsp_result, rsp_flags, rsp_timeout); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        issue(6'h20, 32'h3, 32'h2, 32'h1, 15'h0001);
        while (apu_req === 1'b1 && req_cycles < 20) begin
            req_cycles++;
            tick();
        end
        checks++; if (req_cycles !== 8) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 8", req_cycles); end
        checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_result !== 32'h0 || rsp_flags !== 5'h0) begin errors++; $display("FAIL timeout_rsp: got v=%b t=%b r=%h f=%h expected 1/1/0/0", rsp_valid, rsp_timeout, rsp_result, rsp_flags); end
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL timeout_no_spurious: got %b expected 0", err_spurious); end
        apu_rvalid = 1'b1; apu_result = 32'h5555_AAAA; apu_flags_i = 5'h1F;
        tick();
        apu_rvalid = 1'b0; apu_result = 32'h0; apu_flags_i = 5'h0;
        checks++; if (err_spurious !== 1'b1 || rsp_result !== 32'h0 || rsp_timeout !== 1'b1) begin errors++; $display("FAIL late_rvalid: got err=%b r=%h t=%b expected 1/0/1", err_spurious, rsp_result, rsp_timeout); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (err_spurious !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL spurious_sticky: got err=%b rdy=%b expected 1/1", err_spurious, cmd_ready); end
    endtask

    task automatic test_timeout_boundary();
        issue(6'h07, 32'h0, 32'h0, 32'h9, 15'h0);
        apu_gnt = 1'b1;
        tick();
        apu_gnt = 1'b0;
        repeat (6) tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL boundary_pending: got v=%b busy=%b expected 0/1", rsp_valid, busy); end
        apu_rvalid = 1'b1; apu_result = 32'h0000_1234; apu_flags_i = 5'h05;
        tick();
        apu_rvalid = 1'b0; apu_result = 32'h0; apu_flags_i = 5'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_result !== 32'h1234 || rsp_flags !== 5'h05) begin errors++; $display("FAIL boundary_rsp: got v=%b t=%b r=%h f=%h expected 1/0/1234/05", rsp_valid, rsp_timeout, rsp_result, rsp_flags); end
    endtask

    // Continues from the response left pending by the boundary test.
    task automatic test_backpressure();
        cmd_valid = 1'b1; cmd_op = 6'h2A; cmd_operands = '{default: 32'h77}; cmd_flags = 15'h1111;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h1234 || cmd_ready !== 1'b0) begin errors++; $display("FAIL backpressure%0d: got v=%b r=%h rdy=%b expected 1/1234/0", i, rsp_valid, rsp_result, cmd_ready); end
            tick();
        end
        checks++; if (apu_op !== 6'h07 || apu_operands[0] !== 32'h9) begin errors++; $display("FAIL backpressure_ignored: got op=%h o0=%h expected 07/9", apu_op, apu_operands[0]); end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL backpressure_release: got rdy=%b v=%b expected 1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_reset_mid_wait();
        issue(6'h15, 32'hC, 32'hB, 32'hA, 15'h0ABC);
        apu_gnt = 1'b1;
        tick();
        apu_gnt = 1'b0;
        checks++; if (busy !== 1'b1 || apu_req !== 1'b0) begin errors++; $display("FAIL midwait_state: got busy=%b req=%b expected 1/0", busy, apu_req); end
        #2 n_reset = 1'b0;
        #1;
        checks++; if ({cmd_ready, apu_req, rsp_valid, rsp_timeout, busy, err_spurious} !== 6'b100000) begin errors++; $display("FAIL midwait_async: got %b expected 100000", {cmd_ready, apu_req, rsp_valid, rsp_timeout, busy, err_spurious}); end
        checks++; if (apu_op !== 6'h0 || apu_operands[0] !== 32'h0 || apu_flags_o !== 15'h0 || rsp_result !== 32'h0) begin errors++; $display("FAIL midwait_regs: got op=%h o0=%h fl=%h r=%h expected 0", apu_op, apu_operands[0], apu_flags_o, rsp_result); end
        tick();
        n_reset = 1'b1;
        tick();
        issue(6'h02, 32'h0, 32'h0, 32'h3, 15'h0);
        checks++; if (apu_req !== 1'b1 || apu_op !== 6'h02) begin errors++; $display("FAIL post_reset_accept: got req=%b op=%h expected 1/02", apu_req, apu_op); end
        apu_gnt = 1'b1; apu_rvalid = 1'b1; apu_result = 32'h7; apu_flags_i = 5'h0;
        tick();
        apu_gnt = 1'b0; apu_rvalid = 1'b0; apu_result = 32'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h7 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL post_reset_rsp: got v=%b r=%h t=%b expected 1/7/0", rsp_valid, rsp_result, rsp_timeout); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_reset      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = '0;
        cmd_operands = '{default: '0};
        cmd_flags    = '0;
        apu_gnt      = 1'b0;
        apu_rvalid   = 1'b0;
        apu_result   = '0;
        apu_flags_i  = '0;
        rsp_ready    = 1'b0;
        repeat (2) tick();
        test_reset();
        n_reset = 1'b1;
        tick();
        test_single_cycle();
        test_stalled_grant();
        test_timeout();
        test_timeout_boundary();
        test_backpressure();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apu_initiator.md
APU_INITIATOR -- requirements
Module: apu_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES SHALL be declared: default 255, meaning the number of cycles spent in REQ plus WAIT before a request is abandoned; 0 SHALL disable the timeout.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 n_reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered by the core side.
REQ-005 cmd_ready  output  1  initiator can accept a command.
REQ-006 cmd_op  input  6  APU opcode of the offered command.
REQ-007 cmd_operands  input  3x32 (unpacked [2:0])  operand words of the offered command.
REQ-008 cmd_flags  input  15  APU flags of the offered command.
REQ-009 apu_req  output  1  request to the accelerator.
REQ-010 apu_op  output  6  latched opcode.
REQ-011 apu_operands  output  3x32  latched operands.
REQ-012 apu_flags_o  output  15  latched flags.
REQ-013 apu_gnt  input  1  accelerator grant.
REQ-014 apu_rvalid  input  1  accelerator result valid.
REQ-015 apu_result  input  32  accelerator result word.
REQ-016 apu_flags_i  input  5  accelerator result flags.
REQ-017 rsp_valid  output  1  response available to the core side.
REQ-018 rsp_ready  input  1  core side accepts the response.
REQ-019 rsp_result  output  32  captured result.
REQ-020 rsp_flags  output  5  captured flags.
REQ-021 rsp_timeout  output  1  the response is a timeout, not an accelerator result.
REQ-022 busy  output  1  state is not IDLE.
REQ-023 err_spurious  output  1  sticky flag: apu_rvalid was seen with no request outstanding.

Function
REQ-024 The FSM SHALL have four states (IDLE, REQ, WAIT, RESP); cmd_ready SHALL equal (state==IDLE), rsp_valid SHALL equal (state==RESP), and apu_req SHALL equal (state==REQ).
REQ-025 IDLE: on cmd_valid&&cmd_ready, op, operands and flags SHALL be registered onto apu_op, apu_operands and apu_flags_o, and the next state SHALL be REQ. apu_req therefore rises one cycle after acceptance.
REQ-026 apu_op, apu_operands and apu_flags_o SHALL hold stable from acceptance until the next accepted command.
REQ-027 REQ, apu_gnt&&apu_rvalid in the same cycle: apu_result and apu_flags_i SHALL be captured, rsp_timeout SHALL be cleared, and the next state SHALL be RESP.
REQ-028 REQ, apu_gnt without apu_rvalid: the next state SHALL be WAIT. REQ without apu_gnt: the FSM SHALL stay in REQ with apu_req held high.
REQ-029 WAIT, apu_rvalid: result and flags SHALL be captured, rsp_timeout SHALL be cleared, and the next state SHALL be RESP.
REQ-030 RESP: outputs SHALL hold until rsp_ready, then the next state SHALL be IDLE; cmd_ready SHALL be 0 in RESP even when rsp_ready is high.
REQ-031 Timeout counter (width clog2(TIMEOUT_CYCLES+1)): it SHALL clear on entry to REQ and increment every REQ/WAIT cycle that does not complete.
REQ-032 Timeout trigger: if TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES-1 without completion, the next state SHALL be RESP with rsp_result=0, rsp_flags=0, rsp_timeout=1.
REQ-033 Completion and timeout in the same cycle: completion SHALL win, with rsp_timeout=0.
REQ-034 apu_rvalid in IDLE or RESP SHALL be ignored for data and SHALL set err_spurious, which clears only on reset; this includes a late rvalid after a timeout.
REQ-035 Minimum round trip: command accepted at cycle N, gnt&&rvalid at N+1, rsp_valid at N+2, cmd_ready again at N+3 if rsp_ready is high at N+2.

Reset
REQ-036 While n_reset is low the state SHALL be IDLE, which makes cmd_ready=1.
REQ-037 While n_reset is low, apu_req, rsp_valid, rsp_timeout, busy and err_spurious SHALL be 0.
REQ-038 While n_reset is low, all latched op/operand/flag/result registers and the counter SHALL be 0.
REQ-039 Reset asserted mid-transaction SHALL abandon the transaction immediately: apu_req drops asynchronously and no response is produced.

Verification
REQ-040 Single-cycle op: cmd_op=6'h01, operands {0,0,5}; gnt=rvalid=1 in the first REQ cycle with result 32'h5 -> rsp_valid 2 cycles after accept, rsp_result=5, rsp_timeout=0.
REQ-041 Stalled grant: gnt withheld for 3 cycles, rvalid 2 cycles after gnt -> apu_req high for exactly 4 cycles with operands stable; result captured.
REQ-042 Timeout with TIMEOUT_CYCLES=8: gnt never asserted -> apu_req high 8 cycles, then rsp_valid=1, rsp_timeout=1, rsp_result=0; a later rvalid sets err_spurious=1.
REQ-043 Boundary at TIMEOUT_CYCLES=8: rvalid arrives on the 8th WAIT/REQ cycle -> normal response with rsp_timeout=0.
REQ-044 Response backpressure: rsp_ready held low for 5 cycles -> rsp_valid and rsp_result stable, cmd_ready=0 throughout, cmd_valid ignored.
REQ-045 Reset mid-WAIT: n_reset pulsed low -> all outputs return to reset values within the same cycle; the next command is accepted normally.
